// File: rtl/ay_psg_pkg.sv
// Shared constants and helpers for the AY-style PSG front end: register map,
// implemented-width masks and LFSR definition.
package ay_psg_pkg;

  localparam int unsigned LfsrWidth = 17;
  localparam logic [LfsrWidth-1:0] LfsrSeed = 17'h00001;
  localparam int unsigned LfsrTapA = 0;
  localparam int unsigned LfsrTapB = 3;

  localparam logic [3:0] R_NOISE = 4'd6;
  localparam logic [3:0] R_MIXER = 4'd7;

  function automatic logic [3:0] r_tone_fine(input int unsigned ch);
    return 4'(2 * ch);
  endfunction

  function automatic logic [3:0] r_tone_coarse(input int unsigned ch);
    return 4'(2 * ch + 1);
  endfunction

  function automatic logic [3:0] r_amp(input int unsigned ch);
    return 4'(8 + ch);
  endfunction

  function automatic logic [7:0] low_ones(input int unsigned n);
    logic [8:0] v;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction

  // Bits actually stored for each register index; absent channels and R11..R13 store nothing.
  function automatic logic [7:0] reg_mask(input logic [3:0] idx, input int unsigned num_ch,
                                          input int unsigned tone_bits,
                                          input int unsigned noise_bits);
    logic [7:0] m;
    m = 8'h00;
    if (idx < 4'd6) begin
      if (32'(idx[3:1]) < num_ch) m = idx[0] ? low_ones(tone_bits - 8) : 8'hFF;
    end else if (idx == R_NOISE) begin
      m = low_ones(noise_bits);
    end else if (idx == R_MIXER) begin
      m = 8'hFF;
    end else if (idx <= 4'd10) begin
      if (32'(idx) - 32'd8 < num_ch) m = 8'h1F;
    end else if (idx >= 4'd14) begin
      m = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/ay_psg_regfile_gen_counter.sv
// Period counter shared by tone and noise generators: expires every max(period,1) ticks,
// and a period lowered below the running count expires on the very next tick.
module ay_period_counter #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] period_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc, period_eff;

  always_comb begin
    period_eff = (period_i == '0) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, period_i};
    cnt_inc    = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    expire_o   = tick_i && (cnt_inc >= period_eff);
    cnt_d      = cnt_q;
    if (tick_i) cnt_d = expire_o ? '0 : cnt_inc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ay_psg_regfile_gen.sv
// PSG front end: bus-addressed register file, prescaled tone/noise generators and
// per-channel mixer, with registered waveform, amplitude and envelope-select outputs.
module ay_psg_regfile_gen
  import ay_psg_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned TONE_BITS    = 12,
  parameter int unsigned NOISE_BITS   = 5,
  parameter int unsigned CLK_DIV      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                bus_data_i,
  input  logic                      bus_latch_i,
  input  logic                      bus_write_i,
  output logic [7:0]                read_data_o,
  output logic [NUM_CHANNELS-1:0]   chan_out_o,
  output logic [4*NUM_CHANNELS-1:0] amp_out_o,
  output logic [NUM_CHANNELS-1:0]   env_mode_o
);

  localparam int unsigned PrescW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_DIV - 1);

  logic [7:0]                regs_q [16];
  logic [7:0]                regs_d [16];
  logic [3:0]                index_q, index_d;
  logic [7:0]                read_data_q;
  logic [PrescW-1:0]         presc_q, presc_d;
  logic                      tick;
  logic [NUM_CHANNELS-1:0]   tone_q, tone_d, tone_expire;
  logic                      noise_expire;
  logic [LfsrWidth-1:0]      lfsr_q, lfsr_d;
  logic [NUM_CHANNELS-1:0]   chan_q, chan_d, env_q, env_d;
  logic [4*NUM_CHANNELS-1:0] amp_q, amp_d;

  // Latch takes priority over write when both are asserted.
  always_comb begin
    regs_d  = regs_q;
    index_d = index_q;
    if (bus_latch_i) begin
      index_d = bus_data_i[3:0];
    end else if (bus_write_i) begin
      regs_d[index_q] = bus_data_i & reg_mask(index_q, NUM_CHANNELS, TONE_BITS, NOISE_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      index_q <= '0;
    end else begin
      regs_q  <= regs_d;
      index_q <= index_d;
    end
  end

  assign tick    = (presc_q == PrescLast);
  assign presc_d = tick ? '0 : presc_q + PrescW'(1);

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [TONE_BITS-1:0] period;
    assign period = {regs_q[r_tone_coarse(ch)][TONE_BITS-9:0], regs_q[r_tone_fine(ch)]};

    ay_period_counter #(
      .WIDTH(TONE_BITS)
    ) u_tone_cnt (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .period_i(period),
      .expire_o(tone_expire[ch])
    );

    assign amp_d[4*ch +: 4] = regs_q[r_amp(ch)][4] ? 4'hF : regs_q[r_amp(ch)][3:0];
    assign env_d[ch]        = regs_q[r_amp(ch)][4];
    // Mixer bits are disables: a set bit forces that source high.
    assign chan_d[ch] = (tone_q[ch] | regs_q[R_MIXER][ch]) &
                        (lfsr_q[0] | regs_q[R_MIXER][3+ch]);
  end

  ay_period_counter #(
    .WIDTH(NOISE_BITS)
  ) u_noise_cnt (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick),
    .period_i(regs_q[R_NOISE][NOISE_BITS-1:0]),
    .expire_o(noise_expire)
  );

  assign tone_d = tone_q ^ tone_expire;
  assign lfsr_d = noise_expire ?
                  {lfsr_q[LfsrTapA] ^ lfsr_q[LfsrTapB], lfsr_q[LfsrWidth-1:1]} : lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      tone_q      <= '0;
      lfsr_q      <= LfsrSeed;
      read_data_q <= '0;
      chan_q      <= '0;
      amp_q       <= '0;
      env_q       <= '0;
    end else begin
      presc_q     <= presc_d;
      tone_q      <= tone_d;
      lfsr_q      <= lfsr_d;
      read_data_q <= regs_q[index_q];
      chan_q      <= chan_d;
      amp_q       <= amp_d;
      env_q       <= env_d;
    end
  end

  assign read_data_o = read_data_q;
  assign chan_out_o  = chan_q;
  assign amp_out_o   = amp_q;
  assign env_mode_o  = env_q;

endmodule

// File: tb/tb_ay_psg_regfile_gen.sv
// Bench for ay_psg_regfile_gen: directed register/tone/noise/amplitude cases plus random bus
// traffic, checked every cycle against an arithmetic model for CLK_DIV=1 and CLK_DIV=3.
module tb_ay_psg_regfile_gen;

  localparam int NCH = 3;
  localparam int TB  = 12;
  localparam int NB  = 5;

  logic        clk, reset;
  logic [7:0]  bus_data;
  logic        bus_latch, bus_write;
  logic [7:0]  rd0, rd1;
  logic [2:0]  chan0, chan1, env0, env1;
  logic [11:0] amp0, amp1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b1;

  ay_psg_regfile_gen #(
    .NUM_CHANNELS(NCH), .TONE_BITS(TB), .NOISE_BITS(NB), .CLK_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .bus_data_i(bus_data), .bus_latch_i(bus_latch),
    .bus_write_i(bus_write), .read_data_o(rd0), .chan_out_o(chan0), .amp_out_o(amp0),
    .env_mode_o(env0)
  );

  ay_psg_regfile_gen #(
    .NUM_CHANNELS(NCH), .TONE_BITS(TB), .NOISE_BITS(NB), .CLK_DIV(3)
  ) dut_div3 (
    .clk(clk), .reset(reset), .bus_data_i(bus_data), .bus_latch_i(bus_latch),
    .bus_write_i(bus_write), .read_data_o(rd1), .chan_out_o(chan1), .amp_out_o(amp1),
    .env_mode_o(env1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: shared register file, per-instance generators.
  int m_regs [16];
  int m_idx;
  int m_cyc [2];
  int m_cnt [2][NCH];
  int m_tone [2][NCH];
  int m_ncnt [2];
  int m_lfsr [2];
  int e_read;
  int e_chan [2];
  int e_amp [2];
  int e_env [2];

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int impl_mask(input int r);
    if (r < 6) return (r / 2 < NCH) ? ((r % 2 == 0) ? 255 : (1 << (TB - 8)) - 1) : 0;
    if (r == 6) return (1 << NB) - 1;
    if (r == 7) return 255;
    if (r <= 10) return (r - 8 < NCH) ? 31 : 0;
    if (r >= 14) return 255;
    return 0;
  endfunction

  // Returns the count after one tick; 0 means the period expired.
  function automatic int next_cnt(input int cnt, input int p);
    int pe;
    pe = (p == 0) ? 1 : p;
    return (cnt + 1 >= pe) ? 0 : cnt + 1;
  endfunction

  task automatic model_step();
    int r7, a, p, nz, fb;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_idx  = 0;
      e_read = 0;
      for (int k = 0; k < 2; k++) begin
        m_cyc[k] = 0; m_ncnt[k] = 0; m_lfsr[k] = 1;
        e_chan[k] = 0; e_amp[k] = 0; e_env[k] = 0;
        for (int ch = 0; ch < NCH; ch++) begin
          m_cnt[k][ch]  = 0;
          m_tone[k][ch] = 0;
        end
      end
      return;
    end
    r7     = m_regs[7];
    e_read = m_regs[m_idx];
    for (int k = 0; k < 2; k++) begin
      e_chan[k] = 0; e_amp[k] = 0; e_env[k] = 0;
      nz = m_lfsr[k] & 1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (((m_tone[k][ch] | ((r7 >> ch) & 1)) & (nz | ((r7 >> (3 + ch)) & 1))) != 0)
          e_chan[k] += 1 << ch;
        a = m_regs[8 + ch];
        e_amp[k] += (((a & 16) != 0) ? 15 : (a & 15)) << (4 * ch);
        if ((a & 16) != 0) e_env[k] += 1 << ch;
      end
      if (m_cyc[k] % div_of(k) == div_of(k) - 1) begin
        for (int ch = 0; ch < NCH; ch++) begin
          p = m_regs[2 * ch] + 256 * m_regs[2 * ch + 1];
          m_cnt[k][ch] = next_cnt(m_cnt[k][ch], p);
          if (m_cnt[k][ch] == 0) m_tone[k][ch] ^= 1;
        end
        m_ncnt[k] = next_cnt(m_ncnt[k], m_regs[6]);
        if (m_ncnt[k] == 0) begin
          fb = (m_lfsr[k] ^ (m_lfsr[k] >> 3)) & 1;
          m_lfsr[k] = (m_lfsr[k] >> 1) | (fb << 16);
        end
      end
      m_cyc[k]++;
    end
    if (bus_latch) m_idx = int'(bus_data) & 15;
    else if (bus_write) m_regs[m_idx] = int'(bus_data) & impl_mask(m_idx);
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_data", 32'(rd0), 32'(e_read));
      chk("chan_out", 32'(chan0), 32'(e_chan[0]));
      chk("amp_out", 32'(amp0), 32'(e_amp[0]));
      chk("env_mode", 32'(env0), 32'(e_env[0]));
      chk("read_data_div3", 32'(rd1), 32'(e_read));
      chk("chan_out_div3", 32'(chan1), 32'(e_chan[1]));
      chk("amp_out_div3", 32'(amp1), 32'(e_amp[1]));
      chk("env_mode_div3", 32'(env1), 32'(e_env[1]));
    end
  end

  task automatic bus(input logic l, input logic w, input logic [7:0] d);
    @(negedge clk);
    bus_latch = l;
    bus_write = w;
    bus_data  = d;
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [7:0] v);
    bus(1'b1, 1'b0, {4'h0, r});
    bus(1'b0, 1'b1, v);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] r, input logic [7:0] exp);
    bus(1'b1, 1'b0, {4'h0, r});
    bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk(name, 32'(rd0), 32'(exp));
  endtask

  // Counts negedges until chan_out[0] of the CLK_DIV=1 instance changes; bus held idle.
  task automatic wait_tog(output int n);
    logic s;
    s = chan0[0];
    n = 0;
    do begin
      @(negedge clk);
      bus_latch = 1'b0;
      bus_write = 1'b0;
      n++;
    end while (chan0[0] == s && n < 100);
  endtask

  initial begin
    int n, r;
    reset = 1'b1; bus_latch = 1'b0; bus_write = 1'b0; bus_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_read", 32'(rd0), 32'h0);
    chk("reset_chan", 32'(chan0), 32'h0);
    chk("reset_amp", 32'(amp0), 32'h0);
    chk("reset_env", 32'(env0), 32'h0);
    reset = 1'b0;

    wr_reg(4'd7, 8'hA5);
    rd_chk("read_r7", 4'd7, 8'hA5);
    wr_reg(4'd1, 8'hFF);
    rd_chk("read_coarse_masked", 4'd1, 8'h0F);
    wr_reg(4'd11, 8'h55);
    rd_chk("read_r11_absent", 4'd11, 8'h00);

    wr_reg(4'd3, 8'h0A);
    bus(1'b1, 1'b0, 8'h07);
    bus(1'b1, 1'b1, 8'h03);
    bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("latch_wins_index", 32'(rd0), 32'h0A);
    rd_chk("latch_wins_no_write", 4'd7, 8'hA5);

    wr_reg(4'd8, 8'h0C);
    bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("amp_direct", 32'(amp0[3:0]), 32'hC);
    chk("env_off", 32'(env0[0]), 32'h0);
    wr_reg(4'd8, 8'h13);
    bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("amp_env_forced", 32'(amp0[3:0]), 32'hF);
    chk("env_on", 32'(env0[0]), 32'h1);

    wr_reg(4'd7, 8'h38);
    wr_reg(4'd1, 8'h00);
    wr_reg(4'd0, 8'h04);
    bus(1'b0, 1'b0, 8'h00);
    wait_tog(n); wait_tog(n); wait_tog(n);
    chk("tone_period4", 32'(n), 32'd4);
    wr_reg(4'd0, 8'h00);
    bus(1'b0, 1'b0, 8'h00);
    wait_tog(n); wait_tog(n); wait_tog(n);
    chk("tone_period0", 32'(n), 32'd1);
    wr_reg(4'd0, 8'h08);
    bus(1'b0, 1'b0, 8'h00);
    wait_tog(n); wait_tog(n);
    // Write lands when the count is 2; with period 2 the next tick must expire.
    bus(1'b0, 1'b1, 8'h02);
    wait_tog(n);
    chk("tone_shrink", 32'(n), 32'd3);

    @(negedge clk);
    reset = 1'b1; bus_latch = 1'b0; bus_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_read", 32'(rd0), 32'h0);
    chk("midrun_reset_chan", 32'(chan0), 32'h0);
    chk("midrun_reset_amp", 32'(amp0), 32'h0);
    chk("midrun_reset_env", 32'(env0), 32'h0);
    wr_reg(4'd7, 8'h07);
    bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("noise_seed_bit3", 32'(chan0), 32'h0);
    repeat (13) @(negedge clk);
    chk("noise_bit16", 32'(chan0), 32'h0);
    @(negedge clk);
    chk("noise_bit17", 32'(chan0), 32'h7);

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      reset     = (r < 2);
      bus_latch = (r >= 2 && r < 30) || (r >= 75 && r < 78);
      bus_write = (r >= 30 && r < 78);
      bus_data  = 8'($urandom);
      if (bus_write && !bus_latch) begin
        if (m_idx == 1 || m_idx == 3 || m_idx == 5) bus_data = 8'($urandom_range(0, 1));
        else if (m_idx <= 6) bus_data = 8'($urandom_range(0, 12));
      end
    end
    @(negedge clk);
    reset = 1'b0; bus_latch = 1'b0; bus_write = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ay_psg_regfile_gen.md
Name: ay_psg_regfile_gen

Overview:
Next-generation AY-3-891x-style PSG front end. Combines a bus-addressed 16-entry register file (latch-address / write / read cycles) with parametrised tone generators, a noise LFSR generator and the per-channel mixer. Sits between the pin-level bus decoder and the amplitude/DAC stage. Delivers mixed 1-bit channel waveforms plus per-channel 4-bit amplitude codes.

Parameters:
NUM_CHANNELS, 3, number of tone channels; legal range 1..3, mapped onto the AY register layout.
TONE_BITS, 12, tone period width; R(2i) supplies [7:0], R(2i+1)[TONE_BITS-9:0] supplies the upper bits.
NOISE_BITS, 5, noise period width, taken from R6.
CLK_DIV, 8, generator prescale; all generators advance once per CLK_DIV clocks; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_data  in  8  data/address bus
bus_latch  in  1  latch register index from bus_data[3:0]
bus_write  in  1  write bus_data to the latched register
read_data  out  8  registered contents of the latched register
chan_out  out  NUM_CHANNELS  mixed waveform per channel
amp_out  out  4*NUM_CHANNELS  amplitude code; channel i in [4i+3:4i]
env_mode  out  NUM_CHANNELS  R(8+i)[4], envelope-select flag per channel

Behaviour:
- Reset (synchronous): all registers 0, latched index 0, read_data 0, prescaler 0, all period counters 0, tone states 0, LFSR 17'h00001. Outputs: chan_out 0, amp_out 0, env_mode 0.
- Bus, one action per clock:
  - bus_latch=1: index <= bus_data[3:0]. Upper nibble ignored.
  - bus_write=1 with bus_latch=0: reg[index] <= bus_data masked to implemented width.
  - Both high: the latch wins and no write occurs.
- Implemented widths:
  - Tone fine registers: 8 bits.
  - Tone coarse registers: TONE_BITS-8 bits.
  - R6: NOISE_BITS.
  - R7: 8 bits.
  - R8..R10: 5 bits.
  - R14, R15: 8 bits (plain storage).
  - Registers of absent channels and R11..R13: read 0, writes dropped.
- read_data: reg[index] masked, registered; valid 1 clock after the index changes or after a write.
- Prescaler: counts 0..CLK_DIV-1; tick=1 on the clock where count==CLK_DIV-1, then wraps to 0. CLK_DIV=1 gives a tick every clock.
- Tone channel i:
  - p = period register; p==0 is treated as 1.
  - On each tick: if cnt+1 ≥ p, then cnt <= 0 and the tone state toggles; else cnt <= cnt+1.
  - Half-period = p ticks.
  - The ≥ compare makes a period reduced mid-count expire on the next tick (no full-range wrap).
- Noise:
  - Same counter rule using R6 (0 treated as 1).
  - On expiry: lfsr <= {lfsr[0]^lfsr[3], lfsr[16:1]}.
  - Noise bit = lfsr[0].
  - The LFSR never reaches 0.
- Mixer: chan_out[i] = (tone[i] | R7[i]) & (noise | R7[3+i]). R7 bits 6,7 are stored only.
- Amplitude:
  - amp_out[i] = R(8+i)[3:0] when R(8+i)[4]==0, else 4'hF.
  - env_mode[i] = R(8+i)[4]; the envelope is owned by a downstream block.
- chan_out, amp_out and env_mode are registered: one clock after the generator/register update.
- Reset asserted mid-operation: takes effect on that edge; no partial write survives.

Decomposition:
- Package ay_psg_pkg:
  - register index constants: R_TONE_FINE(i), R_TONE_COARSE(i), R_NOISE, R_MIXER, R_AMP(i);
  - LFSR width 17, seed 17'h1, tap positions 0 and 3.
- One sub-module ay_period_counter (parameter WIDTH; inputs tick, period; output expire). Instantiated NUM_CHANNELS times for tones and once for noise. The tone toggle and the LFSR shift live in the parent.

Test Plan:
- Bus: latch 7, write 8'hA5, latch 7 → read_data==8'hA5 one clock later. Latch 1, write 8'hFF → read 8'h0F (TONE_BITS=12). Latch 11, write 8'h55 → read 8'h00.
- Simultaneous bus_latch and bus_write with bus_data=8'h03 → index==3, previously latched register unchanged.
- Tone: CLK_DIV=1, R0=4, R1=0, R7=8'h38 (noise off, tone on) → chan_out[0] toggles every 4 clocks. Write R0=0 → toggles every clock. Write R0=2 while cnt==3 → toggle on the next tick.
- Noise: R6=1, R7=8'h07, CLK_DIV=1 → chan_out matches the reference LFSR sequence from seed 1 (first bits 1,0,0,0…), period 2^17-1, never all-zero.
- Amplitude: R8=8'h0C → amp_out[3:0]==4'hC, env_mode[0]=0. R8=8'h13 → amp_out[3:0]==4'hF, env_mode[0]=1.
- Reset mid-run after arbitrary writes → next clock: read_data 0, chan_out 0, amp_out 0. The LFSR restarts from 1.
